uart_rx_fifo: RTL and testbench

Receive-side buffer placed directly downstream of the UART receiver. It captures each byte qualified by the receiver's single-cycle data_valid pulse into a circular FIFO. The bus-side register logic drains it through a first-word-fall-through read port. It provides occupancy, a sticky overrun flag, flush control and a level-threshold interrupt, so the CPU can read bursts without losing characters between polls.

---
 rtl/uart_rx_fifo.sv | 80 ++++++++
 tb/tb_uart_rx_fifo.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver: first-word-fall-through read port,
// occupancy, sticky overrun, flush and a level-threshold interrupt.
module uart_rx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            wr_data,
  input  logic                  wr_valid,
  input  logic                  rd_en,
  output logic [7:0]            rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overrun,
  input  logic                  clear_overrun,
  input  logic                  flush,
  input  logic [DEPTH_LOG2:0]   threshold,
  output logic                  irq
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  rd_ok;
  logic                  wr_ok;
  logic                  drop;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_CNT);

  // A full FIFO still accepts a write when a read frees a slot in the same cycle.
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_valid && (!full || rd_ok);
  assign drop  = wr_valid && full && !rd_ok;

  assign rd_data = empty ? '0 : mem[rd_ptr];
  assign irq     = overrun || ((threshold != '0) && (count >= threshold));

  always_ff @(posedge clk) begin
    if (reset_n && wr_ok && !flush) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Overrun is independent of flush; a set in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (clear_overrun) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed vector table, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_uart_rx_fifo;
  localparam int DL    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [7:0]    wr_data = '0;
  logic          wr_valid = 1'b0;
  logic          rd_en = 1'b0;
  logic          clear_overrun = 1'b0;
  logic          flush = 1'b0;
  logic [DL:0]   threshold = '0;
  logic [7:0]    rd_data;
  logic          empty;
  logic          full;
  logic [DL:0]   count;
  logic          overrun;
  logic          irq;

  uart_rx_fifo #(.DEPTH_LOG2(DL)) dut (
    .clk(clk), .reset_n(reset_n), .wr_data(wr_data), .wr_valid(wr_valid),
    .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .full(full),
    .count(count), .overrun(overrun), .clear_overrun(clear_overrun),
    .flush(flush), .threshold(threshold), .irq(irq)
  );

  always #5 clk = ~clk;

  byte unsigned q[$];
  bit           m_ovr;
  int           checks = 0;
  int           errors = 0;

  typedef struct {
    logic       wv;
    logic [7:0] wd;
    logic       re;
    logic       fl;
    logic       co;
    logic [4:0] thr;
    int         e_count;
    logic [7:0] e_rd;
    logic       e_ovr;
    logic       e_irq;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    int          n;
    byte unsigned head;
    bit          e_irq;
    n     = q.size();
    head  = (n > 0) ? q[0] : 8'h00;
    e_irq = m_ovr || ((threshold != 0) && (n >= int'(threshold)));
    chk({tag, ".count"},   32'(count),   32'(n));
    chk({tag, ".empty"},   32'(empty),   32'(n == 0));
    chk({tag, ".full"},    32'(full),    32'(n == DEPTH));
    chk({tag, ".rd_data"}, 32'(rd_data), 32'(head));
    chk({tag, ".overrun"}, 32'(overrun), 32'(m_ovr));
    chk({tag, ".irq"},     32'(irq),     32'(e_irq));
  endtask

  task automatic model_step(input bit wv, input byte unsigned wd, input bit re,
                            input bit fl, input bit co);
    bit was_full, r_ok;
    was_full = (q.size() == DEPTH);
    r_ok     = re && (q.size() > 0);
    if (wv && was_full && !r_ok) m_ovr = 1'b1;
    else if (co)                 m_ovr = 1'b0;
    if (!fl) begin
      if (r_ok) void'(q.pop_front());
      if (wv && (!was_full || r_ok)) q.push_back(wd);
    end else begin
      q.delete();
    end
  endtask

  // Drive at the falling edge, let the rising edge act, then compare at the next falling edge.
  task automatic cyc(input bit wv, input byte unsigned wd, input bit re,
                     input bit fl, input bit co);
    wr_valid = wv; wr_data = wd; rd_en = re; flush = fl; clear_overrun = co;
    @(posedge clk);
    model_step(wv, wd, re, fl, co);
    @(negedge clk);
    wr_valid = 1'b0; rd_en = 1'b0; flush = 1'b0; clear_overrun = 1'b0;
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{1, 8'hA5, 0, 0, 0, 0,  1, 8'hA5, 0, 0};
    vecs[1]  = '{0, 8'h00, 1, 0, 0, 0,  0, 8'h00, 0, 0};
    vecs[2]  = '{0, 8'h00, 1, 0, 0, 0,  0, 8'h00, 0, 0};
    vecs[3]  = '{1, 8'h11, 1, 0, 0, 0,  1, 8'h11, 0, 0};
    vecs[4]  = '{1, 8'h22, 0, 0, 0, 4,  2, 8'h11, 0, 0};
    vecs[5]  = '{1, 8'h33, 0, 0, 0, 4,  3, 8'h11, 0, 0};
    vecs[6]  = '{1, 8'h44, 0, 0, 0, 4,  4, 8'h11, 0, 1};
    vecs[7]  = '{0, 8'h00, 1, 0, 0, 4,  3, 8'h22, 0, 0};
    vecs[8]  = '{0, 8'h00, 0, 0, 0, 3,  3, 8'h22, 0, 1};
    vecs[9]  = '{0, 8'h00, 0, 0, 0, 0,  3, 8'h22, 0, 0};
    vecs[10] = '{0, 8'h00, 0, 0, 0, 17, 3, 8'h22, 0, 0};
    vecs[11] = '{1, 8'h99, 0, 1, 0, 17, 0, 8'h00, 0, 0};

    q.delete();
    m_ovr = 1'b0;
    #12 reset_n = 1'b1;
    @(negedge clk);
    check_model("reset");

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      threshold = vecs[i].thr;
      cyc(vecs[i].wv, vecs[i].wd, vecs[i].re, vecs[i].fl, vecs[i].co);
      chk($sformatf("vec%0d.count", i), 32'(count),   32'(vecs[i].e_count));
      chk($sformatf("vec%0d.rd", i),    32'(rd_data), 32'(vecs[i].e_rd));
      chk($sformatf("vec%0d.ovr", i),   32'(overrun), 32'(vecs[i].e_ovr));
      chk($sformatf("vec%0d.irq", i),   32'(irq),     32'(vecs[i].e_irq));
    end
    threshold = '0;

    // Fill, overrun, clear precedence, write+read while full
    for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0, 0, 0);
    chk("fill.full", 32'(full), 32'd1);
    chk("fill.count", 32'(count), 32'd16);
    cyc(1, 8'hEE, 0, 0, 0);
    chk("ovr.set", 32'(overrun), 32'd1);
    chk("ovr.count", 32'(count), 32'd16);
    chk("ovr.head", 32'(rd_data), 32'h00);
    chk("ovr.irq", 32'(irq), 32'd1);
    cyc(1, 8'hEF, 0, 0, 1);
    chk("ovr.set_wins", 32'(overrun), 32'd1);
    cyc(0, 8'h00, 0, 0, 1);
    chk("ovr.clear", 32'(overrun), 32'd0);
    cyc(1, 8'h77, 1, 0, 0);
    chk("wr_rd_full.count", 32'(count), 32'd16);
    chk("wr_rd_full.ovr", 32'(overrun), 32'd0);
    for (int i = 1; i <= 16; i++) begin
      chk($sformatf("drain%0d", i), 32'(rd_data), (i == 16) ? 32'h77 : 32'(i));
      cyc(0, 8'h00, 1, 0, 0);
    end
    chk("drain.empty", 32'(empty), 32'd1);
    check_model("drain");

    // Second pass wraps both pointers
    for (int i = 0; i < 16; i++) cyc(1, 8'(8'h10 + i), 0, 0, 0);
    chk("wrap.full", 32'(full), 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("wrap%0d", i), 32'(rd_data), 32'(8'h10 + i));
      cyc(0, 8'h00, 1, 0, 0);
    end
    chk("wrap.rd_empty", 32'(rd_data), 32'h00);

    // Flush beats a concurrent write
    for (int i = 0; i < 5; i++) cyc(1, 8'(8'h50 + i), 0, 0, 0);
    cyc(1, 8'h99, 0, 1, 0);
    chk("flush.count", 32'(count), 32'd0);
    chk("flush.empty", 32'(empty), 32'd1);
    cyc(1, 8'h3C, 0, 0, 0);
    chk("flush.head", 32'(rd_data), 32'h3C);
    check_model("flush");

    // Asynchronous reset mid-operation, with overrun and level irq both active
    for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0, 0, 0);
    cyc(1, 8'hAA, 0, 0, 0);
    cyc(0, 8'h00, 0, 1, 0);
    for (int i = 0; i < 10; i++) cyc(1, 8'(i), 0, 0, 0);
    threshold = 5'd4;
    #1;
    chk("pre_rst.irq", 32'(irq), 32'd1);
    chk("pre_rst.count", 32'(count), 32'd10);
    #1 reset_n = 1'b0;
    #1;
    chk("async_rst.count", 32'(count), 32'd0);
    chk("async_rst.irq", 32'(irq), 32'd0);
    chk("async_rst.ovr", 32'(overrun), 32'd0);
    chk("async_rst.empty", 32'(empty), 32'd1);
    q.delete();
    m_ovr = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_model("post_rst");

    // Randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      bit wv, re, fl, co;
      if ($urandom_range(0, 49) == 0) threshold = 5'($urandom_range(0, 18));
      wv = ($urandom_range(0, 99) < 55);
      re = ($urandom_range(0, 99) < (i % 400 < 200 ? 30 : 70));
      fl = ($urandom_range(0, 199) == 0);
      co = ($urandom_range(0, 29) == 0);
      cyc(wv, 8'($urandom), re, fl, co);
      check_model("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
